// File: rtl/awmc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : awmc_pkg
// Purpose  : Shared encodings for the washing-machine front-panel sequencer.
//            - 3-bit controller stage codes (the idle code is what the
//              controller reports while stopped or paused)
//            - 2-bit panel FSM state encoding
//            - default debounce length
// Revision : 1.0 - initial release
// ============================================================================
package awmc_pkg;

    localparam logic [2:0] c_stage_fill  = 3'd0;
    localparam logic [2:0] c_stage_wash  = 3'd1;
    localparam logic [2:0] c_stage_rinse = 3'd2;
    localparam logic [2:0] c_stage_spin  = 3'd3;
    localparam logic [2:0] c_stage_stop  = 3'd4;
    localparam logic [2:0] c_stage_idle  = 3'd7;

    localparam int c_deb_cycles_default = 16;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_RUN   = 2'd1,
        P_PAUSE = 2'd2,
        P_DONE  = 2'd3
    } panel_state_e;

endpackage : awmc_pkg
`default_nettype wire

// File: rtl/awmc_debounce.sv
`default_nettype none
// ============================================================================
// Module   : awmc_debounce
// Purpose  : Single-input debouncer. The debounced output only follows the
//            raw input after it has differed for DEB_CYCLES consecutive
//            clock edges; shorter glitches are absorbed.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-high reset (db and counter cleared)
//            raw   - undebounced input
//            db    - debounced output (registered)
// Revision : 1.0 - initial release
// ============================================================================
module awmc_debounce
    import awmc_pkg::*;
#(
    parameter int DEB_CYCLES = c_deb_cycles_default
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam logic [15:0] c_cnt_max = 16'(DEB_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        db_q,  db_d;

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (raw != db_q) begin
            // The edge that sees the counter at its limit is the
            // DEB_CYCLES-th consecutive differing sample.
            if (cnt_q == c_cnt_max) begin
                db_d = raw;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db = db_q;

endmodule : awmc_debounce
`default_nettype wire

// File: rtl/awmc_panel.sv
`default_nettype none
// ============================================================================
// Module   : awmc_panel
// Purpose  : Front-panel sequencer for the washing-machine controller.
//            Debounces start/pause buttons and the lid switch, issues a
//            one-cycle start pulse and a level pause, and tracks controller
//            stage/done for LEDs, a per-stage elapsed counter and a buzzer.
// Ports    : clk, reset (async active-high)
//            btn_start_raw, btn_pause_raw, lid_raw - raw panel inputs
//            stage[2:0], done                      - controller status
//            start, pause, lid                     - controller commands
//            disp_stage[2:0], elapsed[7:0]         - stage display
//            run_led, pause_led, done_led, buzzer  - indicators
// Options  : AWMC_PANEL_BUZZER_EN - when defined, buzzer toggles every
//            BEEP_DIV cycles while done; otherwise buzzer is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module awmc_panel
    import awmc_pkg::*;
#(
    parameter int DEB_CYCLES = c_deb_cycles_default,
    parameter int DONE_HOLD  = 200,
    parameter int BEEP_DIV   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_raw,
    input  logic       btn_pause_raw,
    input  logic       lid_raw,
    input  logic [2:0] stage,
    input  logic       done,
    output logic       start,
    output logic       pause,
    output logic       lid,
    output logic [2:0] disp_stage,
    output logic [7:0] elapsed,
    output logic       run_led,
    output logic       pause_led,
    output logic       done_led,
    output logic       buzzer
);

    localparam logic [15:0] c_done_hold = 16'(DONE_HOLD);

    logic w_start_db, w_pause_db, w_lid_db;

    awmc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_start (
        .clk(clk), .reset(reset), .raw(btn_start_raw), .db(w_start_db));
    awmc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_pause (
        .clk(clk), .reset(reset), .raw(btn_pause_raw), .db(w_pause_db));
    awmc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_lid (
        .clk(clk), .reset(reset), .raw(lid_raw), .db(w_lid_db));

    panel_state_e state_q, state_d;
    logic         start_prev_q, pause_prev_q;
    logic         start_ev_q,   start_ev_d;
    logic         pause_ev_q,   pause_ev_d;
    logic         start_q,      start_d;
    logic [15:0]  hold_q,       hold_d;
    logic [2:0]   disp_stage_q, disp_stage_d;
    logic [7:0]   elapsed_q,    elapsed_d;

    // Rising-edge events are registered so they line up one cycle after
    // the debounced rise.
    always_comb begin
        start_ev_d = w_start_db & ~start_prev_q;
        pause_ev_d = w_pause_db & ~pause_prev_q;
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        hold_d  = hold_q;
        unique case (state_q)
            P_IDLE: begin
                if (start_ev_q) begin
                    start_d = 1'b1;
                    state_d = P_RUN;
                end
            end
            P_RUN: begin
                // done outranks a coincident pause press
                if (done) begin
                    state_d = P_DONE;
                    hold_d  = c_done_hold;
                end else if (pause_ev_q) begin
                    state_d = P_PAUSE;
                end
            end
            P_PAUSE: begin
                // Controller resumes on its own when pause drops, so no
                // start pulse is issued here.
                if (pause_ev_q) begin
                    state_d = P_RUN;
                end
            end
            P_DONE: begin
                if (start_ev_q) begin
                    start_d = 1'b1;
                    state_d = P_RUN;
                    hold_d  = '0;
                end else if (hold_q <= 16'd1) begin
                    state_d = P_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

    // Stage display: an idle report (pause or stop) freezes the display
    // and elapsed count; returning to the same stage resumes counting.
    always_comb begin
        disp_stage_d = disp_stage_q;
        elapsed_d    = elapsed_q;
        if (stage != c_stage_idle) begin
            disp_stage_d = stage;
            if (stage != disp_stage_q) begin
                elapsed_d = '0;
            end else if (elapsed_q != 8'hFF) begin
                elapsed_d = elapsed_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= P_IDLE;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            start_ev_q   <= 1'b0;
            pause_ev_q   <= 1'b0;
            start_q      <= 1'b0;
            hold_q       <= '0;
            disp_stage_q <= c_stage_idle;
            elapsed_q    <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= w_start_db;
            pause_prev_q <= w_pause_db;
            start_ev_q   <= start_ev_d;
            pause_ev_q   <= pause_ev_d;
            start_q      <= start_d;
            hold_q       <= hold_d;
            disp_stage_q <= disp_stage_d;
            elapsed_q    <= elapsed_d;
        end
    end

`ifdef AWMC_PANEL_BUZZER_EN
    localparam logic [7:0] c_beep_max = 8'(BEEP_DIV - 1);

    logic [7:0] beep_cnt_q, beep_cnt_d;
    logic       buzzer_q,   buzzer_d;

    always_comb begin
        beep_cnt_d = '0;
        buzzer_d   = 1'b0;
        if (state_d == P_DONE) begin
            if (state_q != P_DONE) begin
                buzzer_d = 1'b1;
            end else if (beep_cnt_q == c_beep_max) begin
                buzzer_d = ~buzzer_q;
            end else begin
                buzzer_d   = buzzer_q;
                beep_cnt_d = beep_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beep_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign buzzer = buzzer_q;
`else
    // Tone divider absent in this build; BEEP_DIV is still referenced so the
    // parameter list is identical either way. Folds to a constant 0.
    localparam bit c_beep_div_used = (BEEP_DIV >= 1);
    assign buzzer = 1'b0 & c_beep_div_used;
`endif

    assign start      = start_q;
    assign pause      = (state_q == P_PAUSE);
    assign lid        = w_lid_db;
    assign disp_stage = disp_stage_q;
    assign elapsed    = elapsed_q;
    assign run_led    = (state_q == P_RUN);
    assign pause_led  = (state_q == P_PAUSE);
    assign done_led   = (state_q == P_DONE);

endmodule : awmc_panel
`default_nettype wire

// File: tb/tb_awmc_panel.sv
`default_nettype none
// ============================================================================
// Module   : tb_awmc_panel
// Purpose  : Self-checking bench for awmc_panel with DEB_CYCLES=4,
//            DONE_HOLD=10, BEEP_DIV=2. Buzzer expectations follow the
//            AWMC_PANEL_BUZZER_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_awmc_panel;
    import awmc_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int DIV  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start_raw, btn_pause_raw, lid_raw, done;
    logic [2:0] stage;
    logic       start, pause, lid, run_led, pause_led, done_led, buzzer;
    logic [2:0] disp_stage;
    logic [7:0] elapsed;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;            // number of rising edges so far

    int exp_start[$];         // edge index at which a start pulse is due

    typedef struct { int edge_i; logic val; } pchg_t;
    typedef struct { int edge_i; logic [3:0] v; } dchk_t;   // {done_led,pause,buzzer,run_led}

    awmc_panel #(.DEB_CYCLES(DEB), .DONE_HOLD(HOLD), .BEEP_DIV(DIV)) dut (
        .clk(clk), .reset(reset),
        .btn_start_raw(btn_start_raw), .btn_pause_raw(btn_pause_raw),
        .lid_raw(lid_raw), .stage(stage), .done(done),
        .start(start), .pause(pause), .lid(lid),
        .disp_stage(disp_stage), .elapsed(elapsed),
        .run_led(run_led), .pause_led(pause_led), .done_led(done_led),
        .buzzer(buzzer)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Start-pulse scoreboard consumer: every pulse must match a queued edge.
    int got_e;
    always @(negedge clk) begin
        if (start === 1'b1) begin
            tests++;
            if (exp_start.size() == 0) begin
                fails++;
                $display("FAIL start_unexpected: pulse at edge %0d, none required", cyc - 1);
            end else begin
                got_e = exp_start.pop_front();
                if (got_e != cyc - 1) begin
                    fails++;
                    $display("FAIL start_timing: pulse at edge %0d, required edge %0d", cyc - 1, got_e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(2);
        tests++;
        if ({start, pause, lid, run_led, pause_led, done_led, buzzer} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {start, pause, lid, run_led, pause_led, done_led, buzzer});
        end
        tests++;
        if (disp_stage !== 3'd7) begin
            fails++; $display("FAIL reset_disp_stage: got %0d required 7", disp_stage);
        end
        tests++;
        if (elapsed !== 8'd0) begin
            fails++; $display("FAIL reset_elapsed: got %0d required 0", elapsed);
        end
        reset = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_start();
        btn_start_raw = 1'b1;
        exp_start.push_back(cyc + DEB + 1);
        wait_cycles(DEB + 3);
        tests++;
        if ({run_led, pause_led, done_led} !== 3'b100) begin
            fails++; $display("FAIL start_run_led: leds got %b required 100", {run_led, pause_led, done_led});
        end
        tests++;
        if (exp_start.size() != 0) begin
            fails++; $display("FAIL start_missing: %0d pulses outstanding, required 0", exp_start.size());
        end
        btn_start_raw = 1'b0;
        wait_cycles(8);
        // second press while running must not pulse start
        btn_start_raw = 1'b1;
        wait_cycles(10);
        btn_start_raw = 1'b0;
        wait_cycles(8);
        tests++;
        if (run_led !== 1'b1) begin
            fails++; $display("FAIL start_second_press: run_led got %b required 1", run_led);
        end
    endtask

    task automatic test_lid();
        lid_raw = 1'b1;
        wait_cycles(DEB - 1);
        lid_raw = 1'b0;
        wait_cycles(6);
        tests++;
        if (lid !== 1'b0) begin
            fails++; $display("FAIL lid_glitch: got %b required 0", lid);
        end
        lid_raw = 1'b1;
        wait_cycles(DEB - 1);
        tests++;
        if (lid !== 1'b0) begin
            fails++; $display("FAIL lid_early: got %b required 0", lid);
        end
        wait_cycles(1);
        tests++;
        if (lid !== 1'b1) begin
            fails++; $display("FAIL lid_latency: got %b required 1", lid);
        end
    endtask

    task automatic test_pause();
        pchg_t exp_pause[$];
        pchg_t p;
        logic  last;
        int    b;
        b    = cyc;
        last = pause;
        exp_pause.push_back('{b + 12 + DEB + 1, 1'b1});
        exp_pause.push_back('{b + 30 + DEB + 1, 1'b0});
        for (int i = 0; i < 45; i++) begin
            // drive for the next edge, index cyc
            btn_pause_raw = (cyc >= b && cyc <= b + 2) ||
                            (cyc >= b + 12 && cyc <= b + 17) ||
                            (cyc >= b + 30 && cyc <= b + 35);
            @(negedge clk);
            if (pause !== last) begin
                tests++;
                if (exp_pause.size() == 0) begin
                    fails++;
                    $display("FAIL pause_unexpected: pause=%b at edge %0d, no change required", pause, cyc - 1);
                end else begin
                    p = exp_pause.pop_front();
                    if (p.edge_i != cyc - 1 || p.val !== pause) begin
                        fails++;
                        $display("FAIL pause_change: got %b at edge %0d, required %b at edge %0d",
                                 pause, cyc - 1, p.val, p.edge_i);
                    end
                end
                last = pause;
            end
        end
        btn_pause_raw = 1'b0;
        tests++;
        if (exp_pause.size() != 0) begin
            fails++; $display("FAIL pause_missing: %0d changes outstanding, required 0", exp_pause.size());
        end
        tests++;
        if ({run_led, pause_led, pause} !== 3'b100) begin
            fails++; $display("FAIL pause_resume: {run,pause_led,pause} got %b required 100",
                              {run_led, pause_led, pause});
        end
    endtask

    task automatic test_stage();
        stage = c_stage_fill;
        wait_cycles(21);
        tests++;
        if (disp_stage !== c_stage_fill || elapsed !== 8'd20) begin
            fails++; $display("FAIL stage_fill: disp %0d elapsed %0d, required 0 20", disp_stage, elapsed);
        end
        stage = c_stage_wash;
        wait_cycles(1);
        tests++;
        if (disp_stage !== c_stage_wash || elapsed !== 8'd0) begin
            fails++; $display("FAIL stage_change: disp %0d elapsed %0d, required 1 0", disp_stage, elapsed);
        end
        wait_cycles(3);
        stage = c_stage_idle;
        wait_cycles(5);
        tests++;
        if (disp_stage !== c_stage_wash || elapsed !== 8'd3) begin
            fails++; $display("FAIL stage_hold: disp %0d elapsed %0d, required 1 3", disp_stage, elapsed);
        end
        stage = c_stage_wash;
        wait_cycles(3);
        tests++;
        if (elapsed !== 8'd6) begin
            fails++; $display("FAIL stage_resume: elapsed %0d, required 6", elapsed);
        end
        stage = c_stage_rinse;
        wait_cycles(300);
        tests++;
        if (disp_stage !== c_stage_rinse || elapsed !== 8'd255) begin
            fails++; $display("FAIL stage_saturate: disp %0d elapsed %0d, required 2 255", disp_stage, elapsed);
        end
        stage = c_stage_stop;
        wait_cycles(1);
        stage = c_stage_spin;
        wait_cycles(2);
        tests++;
        if (disp_stage !== c_stage_spin || elapsed !== 8'd1) begin
            fails++; $display("FAIL stage_spin: disp %0d elapsed %0d, required 3 1", disp_stage, elapsed);
        end
        stage = c_stage_idle;
    endtask

    task automatic test_done_pause();
        dchk_t q[$];
        dchk_t d;
        int    b, off;
        logic  in_done, bz;
        b = cyc;
        for (int k = b; k <= b + 20; k++) begin
            in_done = (k >= b + DEB + 1) && (k < b + DEB + 1 + HOLD);
            off     = k - (b + DEB + 1);
`ifdef AWMC_PANEL_BUZZER_EN
            bz = in_done && (((off / DIV) % 2) == 0);
`else
            bz = 1'b0;
`endif
            q.push_back('{k, {in_done, 1'b0, bz, (k < b + DEB + 1)}});
        end
        for (int i = 0; i <= 20; i++) begin
            btn_pause_raw = (cyc >= b && cyc <= b + 5);
            done          = (cyc == b + DEB + 1);
            @(negedge clk);
            d = q.pop_front();
            tests++;
            if ({done_led, pause, buzzer, run_led} !== d.v || d.edge_i != cyc - 1) begin
                fails++;
                $display("FAIL done_seq: edge %0d {done_led,pause,buzzer,run} got %b required %b (edge %0d)",
                         cyc - 1, {done_led, pause, buzzer, run_led}, d.v, d.edge_i);
            end
        end
        btn_pause_raw = 1'b0;
        done          = 1'b0;
    endtask

    task automatic test_async_reset();
        btn_start_raw = 1'b1;
        exp_start.push_back(cyc + DEB + 1);
        wait_cycles(6);
        btn_start_raw = 1'b0;
        stage = c_stage_spin;
        wait_cycles(6);
        btn_pause_raw = 1'b1;
        wait_cycles(6);
        btn_pause_raw = 1'b0;
        wait_cycles(3);
        tests++;
        if ({pause, pause_led} !== 2'b11) begin
            fails++; $display("FAIL arst_setup: {pause,pause_led} got %b required 11", {pause, pause_led});
        end
        tests++;
        if (exp_start.size() != 0) begin
            fails++; $display("FAIL arst_start_missing: %0d pulses outstanding, required 0", exp_start.size());
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({pause, run_led, pause_led, done_led, start, lid, buzzer} !== 7'b0) begin
            fails++; $display("FAIL arst_outputs: got %b required 0000000",
                              {pause, run_led, pause_led, done_led, start, lid, buzzer});
        end
        tests++;
        if (elapsed !== 8'd0 || disp_stage !== 3'd7) begin
            fails++; $display("FAIL arst_stage: elapsed %0d disp %0d, required 0 7", elapsed, disp_stage);
        end
        stage   = c_stage_idle;
        lid_raw = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(8);
        tests++;
        if ({pause, run_led, lid, disp_stage} !== {3'b000, 3'd7}) begin
            fails++; $display("FAIL arst_after: {pause,run,lid,disp} got %b required 000111",
                              {pause, run_led, lid, disp_stage});
        end
    endtask

    initial begin
        reset         = 1'b1;
        btn_start_raw = 1'b0;
        btn_pause_raw = 1'b0;
        lid_raw       = 1'b0;
        done          = 1'b0;
        stage         = c_stage_idle;
        test_reset();
        test_start();
        test_lid();
        test_pause();
        test_stage();
        test_done_pause();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_awmc_panel
`default_nettype wire
